lmfe_sram_arb: RTL and testbench

Single-port SRAM arbiter for the LMFE engine. It shares the 1024x8 line-buffer SRAM between two requesters: the input-stream writer, which must never stall more than two cycles, and the window fetcher, which reads pixels for the median sorter. Writes are absorbed by a 2-entry posted-write buffer. Reads normally win the port. Buffered writes drain on idle or anti-starvation cycles. Reads that hit a pending write are forwarded from the buffer. The block sits between the filter controller and the SRAM macro.

---
 rtl/lmfe_pkg.sv | 27 ++
 rtl/lmfe_wbuf.sv | 74 +++++++
 rtl/lmfe_sram_arb.sv | 142 ++++++++++++++
 tb/tb_lmfe_sram_arb.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lmfe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lmfe_pkg
// Purpose  : Shared widths, SRAM port-state encoding and the posted-write
//            buffer entry type for the LMFE line-buffer SRAM arbiter.
// Revision : 1.0  initial release
// ============================================================================
package lmfe_pkg;

   localparam int LMFE_AW = 10;
   localparam int LMFE_DW = 8;

   // What the single SRAM port does in a given cycle
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2
   } port_state_t;

   // One posted write waiting for the SRAM port
   typedef struct packed {
      logic [LMFE_AW-1:0] addr;
      logic [LMFE_DW-1:0] data;
   } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/lmfe_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : lmfe_wbuf
// Purpose  : 2-entry posted-write FIFO. Exposes the head entry, the fill
//            count and a parallel address lookup returning the youngest
//            matching data so reads can be forwarded from the buffer.
// Revision : 1.0  initial release
// ============================================================================
module lmfe_wbuf
   import lmfe_pkg::*;
(
   input  logic               clk,
   input  logic               RST,
   input  logic               push,
   input  fifo_entry_t        push_entry,
   input  logic               pop,
   output fifo_entry_t        head,
   output logic [1:0]         count,
   input  logic [LMFE_AW-1:0] lookup_addr,
   output logic               lookup_hit,
   output logic [LMFE_DW-1:0] lookup_data
);

   fifo_entry_t mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic        yng_ptr;
   logic [1:0]  cnt;

   // The caller only pushes when not full and only pops when not empty
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign head    = mem[rd_ptr];
   assign count   = cnt;
   // With two entries the one behind the head is always the younger
   assign yng_ptr = ~rd_ptr;

   // Address match against valid entries; the younger entry takes priority
   always_comb begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
      if (cnt != 2'd0 && mem[rd_ptr].addr == lookup_addr) begin
         lookup_hit  = 1'b1;
         lookup_data = mem[rd_ptr].data;
      end
      if (cnt == 2'd2 && mem[yng_ptr].addr == lookup_addr) begin
         lookup_hit  = 1'b1;
         lookup_data = mem[yng_ptr].data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/lmfe_sram_arb.sv
`default_nettype none
// ============================================================================
// Module   : lmfe_sram_arb
// Purpose  : Single-port line-buffer SRAM arbiter. Reads from the window
//            fetcher normally own the port; stream writes are posted into a
//            2-entry buffer and drained on idle, full, flush or anti-
//            starvation cycles. Reads hitting a pending write are forwarded.
// Revision : 1.0  initial release
// ============================================================================
module lmfe_sram_arb
   import lmfe_pkg::*;
#(
   parameter int AW         = LMFE_AW,
   parameter int DW         = LMFE_DW,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          RST,
   input  logic          W_REQ,
   input  logic [AW-1:0] W_A,
   input  logic [DW-1:0] W_D,
   output logic          W_GNT,
   input  logic          R_REQ,
   input  logic [AW-1:0] R_A,
   output logic          R_GNT,
   output logic          R_QV,
   output logic [DW-1:0] R_Q,
   input  logic          FLUSH,
   output logic          FLUSH_DONE,
   output logic          CEN,
   output logic          WEN,
   output logic [AW-1:0] A,
   output logic [DW-1:0] D,
   input  logic [DW-1:0] Q
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   port_state_t   state;
   fifo_entry_t   head;
   fifo_entry_t   push_entry;
   logic [1:0]    count;
   logic          push;
   logic          pop;
   logic          hit;
   logic [DW-1:0] hit_data;
   logic [SW-1:0] starve;
   logic          qv;
   logic          fwd;
   logic [DW-1:0] fwd_data;

   // A full buffer refuses the writer even if it drains this same cycle
   assign W_GNT      = (count != 2'd2);
   assign push       = W_REQ & W_GNT;
   assign pop        = (state == S_WR);
   assign push_entry = '{addr: W_A, data: W_D};

   lmfe_wbuf u_wbuf (
      .clk         (clk),
      .RST         (RST),
      .push        (push),
      .push_entry  (push_entry),
      .pop         (pop),
      .head        (head),
      .count       (count),
      .lookup_addr (R_A),
      .lookup_hit  (hit),
      .lookup_data (hit_data)
   );

   // Port decision: drain when forced or free, otherwise serve the read
   always_comb begin
      state = S_IDLE;
      if (!RST) begin
         state = S_IDLE;
      end else if (count != 2'd0 &&
                   (FLUSH || !R_REQ || count == 2'd2 || starve == STARVE_LIM)) begin
         state = S_WR;
      end else if (R_REQ && !FLUSH) begin
         state = S_RD;
      end
   end

   // SRAM strobes and read grant for the chosen port state
   always_comb begin
      CEN   = 1'b1;
      WEN   = 1'b1;
      A     = '0;
      D     = '0;
      R_GNT = 1'b0;
      unique case (state)
         S_WR: begin
            CEN = 1'b0;
            WEN = 1'b0;
            A   = head.addr;
            D   = head.data;
         end
         S_RD: begin
            CEN   = 1'b0;
            A     = R_A;
            R_GNT = 1'b1;
         end
         default: begin
            CEN = 1'b1;
         end
      endcase
   end

   assign FLUSH_DONE = RST & FLUSH & (count == 2'd0);

   // Count consecutive reads that bypass pending writes, saturating
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         starve <= '0;
      end else if (state == S_WR || count == 2'd0) begin
         starve <= '0;
      end else if (state == S_RD && starve != STARVE_LIM) begin
         starve <= starve + SW'(1);
      end
   end

   // One-cycle read return, with optional forwarding from the write buffer
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         qv       <= 1'b0;
         fwd      <= 1'b0;
         fwd_data <= '0;
      end else begin
         qv  <= R_GNT;
         fwd <= R_GNT & hit;
         if (R_GNT && hit) begin
            fwd_data <= hit_data;
         end
      end
   end

   assign R_QV = qv;
   assign R_Q  = fwd ? fwd_data : Q;

endmodule
`default_nettype wire

// File: tb/tb_lmfe_sram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_lmfe_sram_arb
// Purpose  : Self-checking bench for lmfe_sram_arb with an SRAM model and a
//            queue-based reference of the arbitration and memory contents.
// Revision : 1.0  initial release
// ============================================================================
module tb_lmfe_sram_arb;

   localparam int AW         = 10;
   localparam int DW         = 8;
   localparam int STARVE_MAX = 4;

   logic          clk = 1'b0;
   logic          RST;
   logic          W_REQ;
   logic [AW-1:0] W_A;
   logic [DW-1:0] W_D;
   logic          W_GNT;
   logic          R_REQ;
   logic [AW-1:0] R_A;
   logic          R_GNT;
   logic          R_QV;
   logic [DW-1:0] R_Q;
   logic          FLUSH;
   logic          FLUSH_DONE;
   logic          CEN;
   logic          WEN;
   logic [AW-1:0] A;
   logic [DW-1:0] D;
   logic [DW-1:0] Q;

   always #5 clk = ~clk;

   lmfe_sram_arb #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
      .clk        (clk),
      .RST        (RST),
      .W_REQ      (W_REQ),
      .W_A        (W_A),
      .W_D        (W_D),
      .W_GNT      (W_GNT),
      .R_REQ      (R_REQ),
      .R_A        (R_A),
      .R_GNT      (R_GNT),
      .R_QV       (R_QV),
      .R_Q        (R_Q),
      .FLUSH      (FLUSH),
      .FLUSH_DONE (FLUSH_DONE),
      .CEN        (CEN),
      .WEN        (WEN),
      .A          (A),
      .D          (D),
      .Q          (Q)
   );

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      init_val = a[DW-1:0] ^ 8'hA5;
   endfunction

   // SRAM macro model: synchronous read, data one cycle after access
   bit [DW-1:0] sram    [1024];
   bit          sram_wr [1024];
   always @(posedge clk) begin
      if (!CEN) begin
         if (!WEN) begin
            sram[A]    <= D;
            sram_wr[A] <= 1'b1;
         end else begin
            Q <= sram_wr[A] ? sram[A] : init_val(A);
         end
      end
   end

   // Reference model: pending writes in order, plus drained memory image
   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t         pend [$];
   bit [DW-1:0] gold    [1024];
   bit          gold_wr [1024];
   int          starve_m;
   bit          exp_qv;
   logic [DW-1:0] exp_q;
   bit          last_gnt;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Architectural value of an address: youngest pending write, else memory
   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      logic [DW-1:0] v;
      v = gold_wr[a] ? gold[a] : init_val(a);
      foreach (pend[i]) begin
         if (pend[i].a == a) v = pend[i].d;
      end
      return v;
   endfunction

   // Drive one cycle of inputs (at posedge+1), check mid-cycle, advance model
   task automatic cycle(input bit rq, input logic [AW-1:0] ra, input bit wq,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd, input bit fl);
      int  n;
      bit  e_wr, e_rd, e_wg;
      wr_t e;
      R_REQ = rq; R_A = ra; W_REQ = wq; W_A = wa; W_D = wd; FLUSH = fl;
      #3;
      n    = pend.size();
      e_wg = (n < 2);
      e_wr = (n > 0) && (fl || !rq || n == 2 || starve_m == STARVE_MAX);
      e_rd = !e_wr && rq && !fl;
      check("w_gnt", W_GNT, e_wg);
      check("r_gnt", R_GNT, e_rd);
      check("cen", CEN, !(e_wr || e_rd));
      check("wen", WEN, !e_wr);
      if (e_wr) begin
         check("wr_addr", A, pend[0].a);
         check("wr_data", D, pend[0].d);
      end
      if (e_rd) check("rd_addr", A, ra);
      check("flush_done", FLUSH_DONE, fl && n == 0);
      check("r_qv", R_QV, exp_qv);
      if (exp_qv) check("r_q", R_Q, exp_q);
      // a same-cycle enqueue is ordered after this read
      exp_qv = e_rd;
      if (e_rd) exp_q = model_read(ra);
      if (e_wr || n == 0) starve_m = 0;
      else if (e_rd && starve_m < STARVE_MAX) starve_m++;
      if (e_wr) begin
         gold[pend[0].a]    = pend[0].d;
         gold_wr[pend[0].a] = 1'b1;
         void'(pend.pop_front());
      end
      if (wq && e_wg) begin
         e.a = wa; e.d = wd;
         pend.push_back(e);
      end
      last_gnt = e_rd;
      @(posedge clk);
      #1;
   endtask

   // Assert reset away from the edge, check immediate outputs, release later
   task automatic apply_reset();
      RST = 1'b0; R_REQ = 1'b0; W_REQ = 1'b0; FLUSH = 1'b0;
      R_A = '0; W_A = '0; W_D = '0;
      #1;
      check("rst_cen", CEN, 1'b1);
      check("rst_wen", WEN, 1'b1);
      check("rst_a", A, 0);
      check("rst_d", D, 0);
      check("rst_r_gnt", R_GNT, 1'b0);
      check("rst_w_gnt", W_GNT, 1'b1);
      check("rst_r_qv", R_QV, 1'b0);
      check("rst_flush_done", FLUSH_DONE, 1'b0);
      pend.delete();
      starve_m = 0;
      exp_qv   = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      RST = 1'b1;
   endtask

   initial begin
      logic [AW-1:0] ra;
      bit            rq;
      int            flen;
      foreach (gold_wr[i]) gold_wr[i] = 1'b0;
      exp_qv = 1'b0; exp_q = '0; starve_m = 0; last_gnt = 1'b0;
      apply_reset();

      // Idle after reset, then a single write drains on the next cycle
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 1, 10'd5, 8'h3C, 0);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);

      // Read flood 0..9 with one write at 100: held off for STARVE_MAX reads
      ra = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(ra < 10, ra, i == 0, 10'd100, 8'h5A, 0);
         if (last_gnt) ra++;
      end

      // Two writes to 7 under read pressure, then a forwarded read of 7
      cycle(1, 10'd20, 1, 10'd7, 8'h11, 0);
      cycle(1, 10'd21, 1, 10'd7, 8'h22, 0);
      for (int i = 0; i < 8 && !last_gnt; i++) cycle(1, 10'd7, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      last_gnt = 1'b0;
      for (int i = 0; i < 8 && !last_gnt; i++) cycle(1, 10'd7, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);

      // Writer held against a full buffer while reads keep coming
      ra = 10'd30;
      for (int i = 0; i < 10; i++) begin
         cycle(1, ra, 1, AW'(40 + i), DW'(i), 0);
         if (last_gnt) ra++;
      end
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);

      // Flush with two pending writes and a held read
      cycle(1, 10'd50, 1, 10'd60, 8'hA1, 0);
      cycle(1, 10'd51, 1, 10'd61, 8'hA2, 0);
      for (int i = 0; i < 4; i++) cycle(1, 10'd52, 0, 0, 0, 1);
      last_gnt = 1'b0;
      for (int i = 0; i < 4 && !last_gnt; i++) cycle(1, 10'd52, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);

      // Reset while the buffer is full and a read return is due
      cycle(1, 10'd60, 1, 10'd70, 8'hB1, 0);
      cycle(1, 10'd61, 1, 10'd71, 8'hB2, 0);
      apply_reset();
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
      last_gnt = 1'b0;
      for (int i = 0; i < 4 && !last_gnt; i++) cycle(1, 10'd70, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);

      // Randomized traffic on a small address range to provoke hits
      rq = 1'b0; ra = '0; flen = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!rq) begin
            rq = ($urandom_range(0, 3) != 0);
            ra = AW'($urandom_range(0, 15));
         end
         if (flen > 0) flen--;
         else if ($urandom_range(0, 40) == 0) flen = int'($urandom_range(1, 6));
         cycle(rq, ra, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
               DW'($urandom), flen > 0);
         if (last_gnt) rq = 1'b0;
      end
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
